// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants, IF/ID record type and fetch FSM encoding.
// Used by the fetch stage, the register pre-decoder and the hazard unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;
    localparam logic [5:0] FN_SRA = 6'd3;
    localparam logic [5:0] FN_JR  = 6'd8;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_PEND = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/reg_predecode.sv
// Combinational register-read pre-decoder: extracts rs/rt and whether the
// instruction actually reads them. Shared with the hazard unit.
module reg_predecode (
    input  logic [31:0] instr,
    input  logic        valid,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic        rs_rena,
    output logic        rt_rena
);
    import mips_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       reads_rs;
    logic       reads_rt;

    assign opcode  = instr[31:26];
    assign funct   = instr[5:0];
    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];

    always_comb begin
        // NOTE: defaults first so every path assigns both flags; otherwise a latch is inferred.
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: reads_rt = 1'b1;
                    FN_JR:                  reads_rs = 1'b1;
                    default: begin
                        reads_rs = 1'b1;
                        reads_rt = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LW: reads_rs = 1'b1;
            OP_SW, OP_BEQ, OP_BNE: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // A bubble must never create a false dependency in the stall unit.
    assign rs_rena = valid & reads_rs;
    assign rt_rena = valid & reads_rt;

endmodule

// File: rtl/if_id_fetch.sv
// MIPS fetch stage + IF/ID register with stall, pending-redirect and pre-decode.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot instruction on redirects.
module if_id_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_stall,
    input  logic        in_redirect,
    input  logic [31:0] in_redirect_pc,
    input  logic [31:0] in_imem_data,
    output logic [31:0] out_imem_addr,
    output logic [31:0] out_id_pc,
    output logic [31:0] out_id_instr,
    output logic        out_id_valid,
    output logic [4:0]  out_rs_addr,
    output logic [4:0]  out_rt_addr,
    output logic        out_rs_rena,
    output logic        out_rt_rena
);
    import mips_pkg::*;

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  pend_pc, pend_pc_n;
    if_id_t       id_q, id_n, fetched;

    assign fetched = '{pc: pc, instr: in_imem_data, valid: 1'b1};

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pend_pc_n = pend_pc;
        id_n      = id_q;
        if (in_stall) begin
            state_n = (state == ST_PEND) ? ST_PEND : ST_HOLD;
            if (in_redirect) begin
                state_n   = ST_PEND;
                pend_pc_n = word_align(in_redirect_pc);
            end
        end else begin
            state_n = ST_RUN;
            // A pending target wins over any redirect presented on the release edge.
            if (state == ST_PEND || in_redirect) begin
                pc_n = (state == ST_PEND) ? pend_pc : word_align(in_redirect_pc);
`ifdef BRANCH_DELAY_SLOT_EN
                id_n = fetched;
`else
                id_n = '{pc: pc, instr: NOP, valid: 1'b0};
`endif
            end else begin
                pc_n = pc + 32'd4;
                id_n = fetched;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!in_rst) begin
            state   <= ST_RUN;
            pc      <= RESET_PC;
            pend_pc <= '0;
            id_q    <= '{pc: '0, instr: NOP, valid: 1'b0};
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pend_pc <= pend_pc_n;
            id_q    <= id_n;
        end
    end

    assign out_imem_addr = pc;
    assign out_id_pc     = id_q.pc;
    assign out_id_instr  = id_q.instr;
    assign out_id_valid  = id_q.valid;

    reg_predecode u_predecode (
        .instr   (id_q.instr),
        .valid   (id_q.valid),
        .rs_addr (out_rs_addr),
        .rt_addr (out_rt_addr),
        .rs_rena (out_rs_rena),
        .rt_rena (out_rt_rena)
    );

endmodule

// File: tb/tb_if_id_fetch.sv
// Self-checking bench for if_id_fetch: directed sequences, a pre-decode vector
// table and randomized lockstep comparison against a behavioural model.
module tb_if_id_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_stall;
    logic        in_redirect;
    logic [31:0] in_redirect_pc;
    logic [31:0] in_imem_data;
    logic [31:0] out_imem_addr;
    logic [31:0] out_id_pc;
    logic [31:0] out_id_instr;
    logic        out_id_valid;
    logic [4:0]  out_rs_addr;
    logic [4:0]  out_rt_addr;
    logic        out_rs_rena;
    logic        out_rt_rena;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    logic [31:0] m_pc, m_id_pc, m_id_instr, m_pend_pc;
    logic        m_id_valid, m_pending;

    assign in_imem_data = mem[out_imem_addr[11:2]];

    always #5 in_clk = ~in_clk;

    if_id_fetch #(.RESET_PC(RST_PC)) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_stall       (in_stall),
        .in_redirect    (in_redirect),
        .in_redirect_pc (in_redirect_pc),
        .in_imem_data   (in_imem_data),
        .out_imem_addr  (out_imem_addr),
        .out_id_pc      (out_id_pc),
        .out_id_instr   (out_id_instr),
        .out_id_valid   (out_id_valid),
        .out_rs_addr    (out_rs_addr),
        .out_rt_addr    (out_rt_addr),
        .out_rs_rena    (out_rs_rena),
        .out_rt_rena    (out_rt_rena)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register-read rules written directly from the ISA description.
    function automatic logic [1:0] ref_reads(input logic [31:0] instr);
        logic [5:0] op, fn;
        op = instr[31:26];
        fn = instr[5:0];
        if (op == 6'd0) begin
            if (fn inside {6'd0, 6'd2, 6'd3}) return 2'b01;
            if (fn == 6'd8) return 2'b10;
            return 2'b11;
        end
        if (op inside {[6'd8:6'd14], 6'd35}) return 2'b10;
        if (op inside {6'd43, 6'd4, 6'd5}) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_edge();
        logic [31:0] fetched;
        fetched = mem[m_pc[11:2]];
        if (!in_rst) begin
            m_pc = RST_PC; m_id_pc = 0; m_id_instr = 0; m_id_valid = 0;
            m_pending = 0; m_pend_pc = 0;
        end else if (in_stall) begin
            if (in_redirect) begin
                m_pending = 1;
                m_pend_pc = in_redirect_pc & ~32'd3;
            end
        end else if (m_pending || in_redirect) begin
            m_id_pc = m_pc;
`ifdef BRANCH_DELAY_SLOT_EN
            m_id_instr = fetched; m_id_valid = 1;
`else
            m_id_instr = 0; m_id_valid = 0;
`endif
            m_pc = m_pending ? m_pend_pc : (in_redirect_pc & ~32'd3);
            m_pending = 0;
        end else begin
            m_id_pc = m_pc; m_id_instr = fetched; m_id_valid = 1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        logic [1:0] rd;
        rd = m_id_valid ? ref_reads(m_id_instr) : 2'b00;
        check("imem_addr", out_imem_addr, m_pc);
        check("id_pc", out_id_pc, m_id_pc);
        check("id_instr", out_id_instr, m_id_instr);
        check("id_valid", 32'(out_id_valid), 32'(m_id_valid));
        check("rs_addr", 32'(out_rs_addr), 32'(m_id_instr[25:21]));
        check("rt_addr", 32'(out_rt_addr), 32'(m_id_instr[20:16]));
        check("rs_rena", 32'(out_rs_rena), 32'(rd[1]));
        check("rt_rena", 32'(out_rt_rena), 32'(rd[0]));
    endtask

    task automatic step();
        @(posedge in_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        rs_en;
        logic        rt_en;
    } pd_vec_t;

    pd_vec_t vecs [10];
    logic [5:0] ops [13];
    logic [5:0] fns [6];

    initial begin
        vecs[0] = '{"sll",     32'h0009_4080, 1'b0, 1'b1};
        vecs[1] = '{"jr",      32'h03E0_0008, 1'b1, 1'b0};
        vecs[2] = '{"lui",     32'h3C08_1234, 1'b0, 1'b0};
        vecs[3] = '{"sw",      32'hAFA8_0004, 1'b1, 1'b1};
        vecs[4] = '{"op3f",    32'hFC00_0000, 1'b0, 1'b0};
        vecs[5] = '{"srl",     32'h0009_4082, 1'b0, 1'b1};
        vecs[6] = '{"addi",    32'h2109_0001, 1'b1, 1'b0};
        vecs[7] = '{"beq",     32'h1109_0003, 1'b1, 1'b1};
        vecs[8] = '{"j",       32'h0800_0040, 1'b0, 1'b0};
        vecs[9] = '{"xori",    32'h3909_0005, 1'b1, 1'b0};
        ops = '{6'd0, 6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd13, 6'd15, 6'd2, 6'd3, 6'h3F};
        fns = '{6'd0, 6'd2, 6'd3, 6'd8, 6'h20, 6'h21};
        for (int i = 0; i < 1024; i++)
            mem[i] = {ops[$urandom_range(0, 12)], 20'($urandom), fns[$urandom_range(0, 5)]};

        mem[32'h100 >> 2] = 32'h8E08_0000;  // lw  $t0,0($s0)
        mem[32'h104 >> 2] = 32'h010A_4820;  // add $t1,$t0,$t2

        in_rst = 1'b0; in_stall = 1'b0; in_redirect = 1'b0; in_redirect_pc = '0;
        m_pc = 0; m_id_pc = 0; m_id_instr = 0; m_id_valid = 0; m_pending = 0; m_pend_pc = 0;

        // Reset and first fetch.
        step(); step();
        check("rst_pc", out_imem_addr, 32'h100);
        check("rst_valid", 32'(out_id_valid), 32'd0);
        check("rst_id_pc", out_id_pc, 32'd0);
        check("rst_rena", {30'd0, out_rs_rena, out_rt_rena}, 32'd0);
        in_rst = 1'b1;
        step();
        check("first_id_pc", out_id_pc, 32'h100);
        check("first_valid", 32'(out_id_valid), 32'd1);
        step();

        // Stall with lw->add dependency visible to the hazard unit.
        in_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_pc", out_imem_addr, 32'h108);
            check("stall_id_pc", out_id_pc, 32'h104);
        end
        check("stall_rs", 32'(out_rs_addr), 32'd8);
        check("stall_rt", 32'(out_rt_addr), 32'd10);
        check("stall_rena", {30'd0, out_rs_rena, out_rt_rena}, 32'd3);
        in_stall = 1'b0;
        step();
        check("release_pc", out_imem_addr, 32'h10C);

        // Pre-decode vector table.
        foreach (vecs[i]) begin
            mem[m_pc[11:2]] = vecs[i].instr;
            step();
            check({"pd_rs_", vecs[i].name}, 32'(out_rs_rena), 32'(vecs[i].rs_en));
            check({"pd_rt_", vecs[i].name}, 32'(out_rt_rena), 32'(vecs[i].rt_en));
        end

        // Redirect from a beq at 0x200 to 0x400.
        mem[32'h200 >> 2] = 32'h1109_0003;
        mem[32'h204 >> 2] = 32'h2109_0001;
        in_redirect = 1'b1; in_redirect_pc = 32'h200;
        step();
        in_redirect = 1'b0;
        step();
        check("beq_in_id", out_id_instr, 32'h1109_0003);
        in_redirect = 1'b1; in_redirect_pc = 32'h400;
        step();
        in_redirect = 1'b0;
        check("redir_pc", out_imem_addr, 32'h400);
        check("redir_id_pc", out_id_pc, 32'h204);
`ifdef BRANCH_DELAY_SLOT_EN
        check("slot_valid", 32'(out_id_valid), 32'd1);
        check("slot_instr", out_id_instr, 32'h2109_0001);
`else
        check("bubble_valid", 32'(out_id_valid), 32'd0);
        check("bubble_instr", out_id_instr, 32'd0);
        check("bubble_rena", {30'd0, out_rs_rena, out_rt_rena}, 32'd0);
`endif

        // Redirect while stalled becomes pending.
        in_stall = 1'b1; in_redirect = 1'b1; in_redirect_pc = 32'h800;
        step();
        check("pend_hold_pc", out_imem_addr, 32'h400);
        in_redirect = 1'b0;
        step();
        check("pend_hold_pc2", out_imem_addr, 32'h400);
        in_stall = 1'b0;
        step();
        check("pend_release_pc", out_imem_addr, 32'h800);

        // Later pending redirect overwrites; release-edge redirect is ignored.
        in_stall = 1'b1; in_redirect = 1'b1; in_redirect_pc = 32'h900;
        step();
        in_redirect_pc = 32'hA03;
        step();
        in_stall = 1'b0; in_redirect_pc = 32'hB00;
        step();
        check("pend_overwrite_pc", out_imem_addr, 32'hA00);

        // Reset while pending discards the target.
        in_stall = 1'b1; in_redirect = 1'b1; in_redirect_pc = 32'hC00;
        step();
        in_rst = 1'b0; in_redirect = 1'b0;
        step();
        check("pend_rst_pc", out_imem_addr, 32'h100);
        in_rst = 1'b1; in_stall = 1'b0;
        step();
        check("pend_rst_advance", out_imem_addr, 32'h104);

        // PC wrap at the top of the address space.
        in_redirect = 1'b1; in_redirect_pc = 32'hFFFF_FFFF;
        step();
        check("wrap_top", out_imem_addr, 32'hFFFF_FFFC);
        in_redirect = 1'b0;
        step();
        check("wrap_zero", out_imem_addr, 32'h0);
        check("wrap_id_pc", out_id_pc, 32'hFFFF_FFFC);

        // Randomized lockstep run.
        for (int i = 0; i < 500; i++) begin
            in_rst         = ($urandom_range(0, 49) != 0);
            in_stall       = ($urandom_range(0, 3) == 0);
            in_redirect    = ($urandom_range(0, 4) == 0);
            in_redirect_pc = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_fetch.md
# if_id_fetch

Fetch stage plus IF/ID pipeline register for the five-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and registers the fetched word into IF/ID. It pre-decodes the IF/ID instruction into rs/rt addresses and read enables for the hazard/stall unit, and obeys that unit's stall output by freezing PC and IF/ID. It also applies branch/jump redirects from ID, with one-cycle flush or delay-slot semantics.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- in_clk  in  1  pipeline clock; all state updates on rising edge.
- in_rst  in  1  reset, synchronous, active-low.
- in_stall  in  1  freeze request from stall unit; sampled on rising edge.
- in_redirect  in  1  branch taken / jump, resolved in ID.
- in_redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- in_imem_data  in  32  instruction at out_imem_addr; combinational memory.
- out_imem_addr  out  32  current PC.
- out_id_pc  out  32  PC of the IF/ID instruction.
- out_id_instr  out  32  IF/ID instruction; 0 (NOP) when bubble.
- out_id_valid  out  1  IF/ID holds a real instruction.
- out_rs_addr  out  5  instr[25:21] of the IF/ID instruction.
- out_rt_addr  out  5  instr[20:16] of the IF/ID instruction.
- out_rs_rena  out  1  instruction reads rs; 0 when !out_id_valid.
- out_rt_rena  out  1  instruction reads rt; 0 when !out_id_valid.

## Operation
- FSM has three states:
  - RUN: normal fetch.
  - HOLD: in_stall asserted.
  - PEND: a redirect arrived while stalled; target held in pend_pc.
- Per-edge priority, highest first: reset > in_stall > redirect (or pending) > advance.
- Reset (in_rst=0): PC=RESET_PC, out_id_pc=0, out_id_instr=0, out_id_valid=0, pend_pc=0, state RUN.
- Stall (in_stall=1): PC and IF/ID hold their values. State goes to HOLD. If in_redirect=1 on this edge, pend_pc is loaded and state goes to PEND; a later redirect while in PEND overwrites pend_pc.
- Redirect (in_redirect=1 and in_stall=0): PC is loaded with {in_redirect_pc[31:2],2'b00}. IF/ID is handled per the Configuration section.
- Stall released in PEND: behaves exactly as a redirect to pend_pc, and in_redirect is ignored on that edge. State returns to RUN.
- Advance: PC <= PC+4, 32-bit wrap (32'hFFFF_FFFC -> 0). IF/ID <= {PC, in_imem_data, valid=1}.
- Pre-decode is combinational from out_id_instr:
  - op=0 (R-type): rs and rt read, except funct 0/2/3 (sll/srl/sra): rt only; funct 8 (jr): rs only.
  - op 8,9,10,11,12,13,14 (addi…xori) and 35 (lw): rs only.
  - op 43 (sw), 4 (beq), 5 (bne): rs and rt.
  - op 15 (lui), 2 (j), 3 (jal), or any other opcode: neither.

## Timing
- Fetch-to-IF/ID latency is one cycle. out_imem_addr changes only on a rising edge.
- The stall unit updates in_stall on the falling edge, so in_stall is stable at every rising edge. No combinational path from in_stall to any output.
- Pre-decode outputs are valid in the same cycle as IF/ID and feed the stall unit's rs/rt inputs with zero latency.
- Redirect penalty:
  - Without the macro: one bubble (out_id_valid=0 for one cycle).
  - With the macro: none; the slot instruction executes.
- Reset mid-stall or while in PEND clears everything; pend_pc is discarded.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: on a redirect edge, IF/ID captures {PC, in_imem_data, 1}, so the delay slot is kept.
- BRANCH_DELAY_SLOT_EN undefined: on a redirect edge, IF/ID loads a bubble {PC, 32'h0, 0}, so the slot is flushed.
- Both builds handle a redirect taken from PEND identically to a direct redirect.

## Structure
- Shared package mips_pkg holds:
  - opcode and funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI, OP_J, OP_JAL, OP_ADDI…OP_XORI, FN_SLL, FN_SRL, FN_SRA, FN_JR);
  - NOP = 32'h0;
  - the fetch FSM state encoding.
- One sub-module, reg_predecode: purely combinational, maps instruction and valid to rs/rt addresses and read enables. The hazard unit can reuse it.

## Test plan
- Reset: hold in_rst=0 for 2 cycles with RESET_PC=0x100, then release -> out_imem_addr=0x100, out_id_valid=0. After the first edge, out_id_pc=0x100 and out_id_valid=1.
- Stall: lw $t0 at 0x100 followed by add $t1,$t0,$t2. Assert in_stall for 2 edges -> PC stays 0x108 and IF/ID stays at 0x104 on both. On release, PC=0x10C. Pre-decode shows rs=8, rt=10, both enables 1.
- Redirect, macro off: beq in IF/ID at 0x200, in_redirect=1, target 0x400 -> next cycle PC=0x400, out_id_valid=0, out_id_instr=0.
- Redirect, macro on: same stimulus -> IF/ID holds the slot at 0x204 with valid=1, and PC=0x400.
- Redirect during stall: in_stall=1 and in_redirect=1 with target 0x800 -> state PEND, PC held. When stall drops with in_redirect=0, PC=0x800 on that edge.
- Pre-decode: sll, jr, lui, sw, and an invalid opcode 6'h3F -> (rs_rena,rt_rena) = (0,1), (1,0), (0,0), (1,1), (0,0).
